pwm_deadtime_gen: RTL and testbench
===================================

# pwm_deadtime_gen

Downstream consumer of the free-running PWM period counter. Compares the counter value against a double-buffered duty setting and drives a complementary high-side/low-side PWM pair with programmable dead time. A new duty value is accepted over a valid/ready handshake and takes effect only at the next period boundary, so PWM periods are never torn.

## Interface

- CW, 4: counter width; period = 2^CW clocks.
- DT, 1: dead-time length in clocks, range 0..15.

- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CNT  in  CW  period counter value, registered upstream, increments by 1 per clock and wraps to 0.
- EN  in  1  output enable.
- DUTY_IN  in  CW+1  requested high time in clocks, 0..2^CW.
- DUTY_VLD  in  1  DUTY_IN valid.
- DUTY_RDY  out  1  pending buffer can accept a value.
- PWM_H  out  1  high-side drive.
- PWM_L  out  1  low-side drive.
- PRD_STB  out  1  one-cycle pulse: new period started and active duty loaded.

## Operation

- Reset values: PWM_H=0, PWM_L=0, PRD_STB=0, DUTY_RDY=0. Internal reset values: state OFF, active duty 0, pending empty, dead-time counter 0.
- DUTY_RDY is registered: it equals NOT pending-full as of the previous edge. It goes to 1 on the first edge after RST releases.
- Handshake:
  - A transfer occurs on an edge where DUTY_VLD=1 and DUTY_RDY=1.
  - On a transfer, the pending buffer takes min(DUTY_IN, 2^CW) and becomes full.
  - DUTY_VLD while DUTY_RDY=0 has no effect. The source must hold the value.
- Boundary: any edge where CNT==0 is sampled.
  - If pending is full, active duty takes the pending value and pending empties.
  - PRD_STB is 1 in the following cycle, whether or not pending was full.
  - The compare in the boundary cycle already uses the newly loaded value (bypass).
- Simultaneous transfer and boundary with pending empty: the transferred value goes to pending, not active. It applies at the next boundary.
- Raw compare: raw = (CNT < duty).
  - duty=0 gives constant 0.
  - duty=2^CW gives constant 1.
  - CNT is zero-extended to CW+1 bits.
- State machine: OFF, HI, LO, DT.
  - OFF: H=0, L=0. If EN=1, go to DT and load the counter with DT.
  - HI: H=1, L=0. If raw=0, go to DT and load DT.
  - LO: H=0, L=1. If raw=1, go to DT and load DT.
  - DT: H=0, L=0. The counter decrements each clock. When it reaches 0, go to HI if raw=1, else LO.
  - With DT=0, DT lasts zero cycles: HI and LO switch directly. H and L are never both 1.
  - Pulses shorter than DT are absorbed. The FSM resolves to the raw value present when DT expires.
  - EN=0 in any state forces OFF on the next edge. This has priority over all other transitions.
- Reset mid-operation: outputs go to 0 immediately (asynchronous). Pending and active duty are cleared, so a pending value is lost.

## Timing

- Latency from the edge sampling CNT to a PWM output change: 1 clock (registered outputs).
- High-side width per period = duty − DT clocks when DT < duty < 2^CW. A full-duty (2^CW) period stays HI with no dead gaps across boundaries.
- Low-side width per period = 2^CW − duty − DT clocks, under the same condition.
- Duty updates never take effect mid-period. Worst-case apply latency from a transfer is 2^CW + 1 clocks.
- Pending refill: DUTY_RDY returns to 1 one clock after the boundary edge that emptied pending.

## Test plan

- Reset: assert RST mid-period with H=1 -> H, L, PRD_STB and DUTY_RDY drop to 0 immediately. One edge after release, DUTY_RDY=1.
- 50% with DT=0, duty=8, EN=1: steady state H high 8 clocks, L high 8 clocks. PRD_STB pulses every 16 clocks.
- Dead time DT=2, duty=8: H high 6 clocks, 2-clock gap, L high 6 clocks, 2-clock gap. H&L is never 1.
- Backpressure: write 4, then 12, with no boundary in between -> second write stalls with RDY=0. At the boundary, 4 becomes active and RDY rises 1 clock later. 12 is accepted and applies at the following boundary.
- Extremes: duty=0 -> L constant 1. duty=16 -> H constant 1. DUTY_IN=20 -> clamped to 16, same as duty=16.
- EN drop mid-HI: next edge H=L=0. On EN rise, both stay 0 for DT clocks, then resolve to the raw compare.

Source files
------------

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary PWM pair with dead time and period-aligned, double-buffered duty.
module pwm_deadtime_gen #(
  parameter int CW = 4,
  parameter int DT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CW-1:0] CNT,
  input  logic          EN,
  input  logic [CW:0]   DUTY_IN,
  input  logic          DUTY_VLD,
  output logic          DUTY_RDY,
  output logic          PWM_H,
  output logic          PWM_L,
  output logic          PRD_STB
);
  typedef enum logic [1:0] {st_off, st_hi, st_lo, st_dt} state_t;
  localparam logic [CW:0] dmax = {1'b1, {CW{1'b0}}};
  state_t state, state_nx, resolve, enter;
  logic [3:0] dtc, dtc_nx;
  logic [CW:0] act, pend, duty;
  logic pend_full, rdy, stb, bnd, xfer, raw, go;
  assign bnd = CNT == '0;
  assign xfer = DUTY_VLD & rdy;
  // a value loaded at this boundary already governs this cycle's compare
  assign duty = (bnd & pend_full) ? pend : act;
  assign raw = {1'b0, CNT} < duty;
  assign resolve = raw ? st_hi : st_lo;
  assign enter = (DT == 0) ? resolve : st_dt;
  assign go = state == st_off ? EN : state == st_hi ? !raw : state == st_lo ? raw : 1'b0;
  always_comb begin
    state_nx = !EN ? st_off : go ? enter : (state == st_dt && dtc <= 4'd1) ? resolve : state;
    dtc_nx = go ? 4'(DT) : state == st_dt ? dtc - 4'd1 : dtc;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= st_off;
      dtc <= '0;
      act <= '0;
      pend <= '0;
      pend_full <= 1'b0;
      rdy <= 1'b0;
      stb <= 1'b0;
    end else begin
      state <= state_nx;
      dtc <= dtc_nx;
      stb <= bnd;
      // ready drops on the accepting edge so a changed source value cannot slip in
      rdy <= ~pend_full & ~xfer;
      if (bnd & pend_full) begin
        act <= pend;
        pend_full <= 1'b0;
      end
      if (xfer) begin
        pend <= (DUTY_IN > dmax) ? dmax : DUTY_IN;
        pend_full <= 1'b1;
      end
    end
  end
  assign DUTY_RDY = rdy;
  assign PRD_STB = stb;
  assign PWM_H = state == st_hi;
  assign PWM_L = state == st_lo;
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb_pwm_deadtime_gen: checks two dead-time variants (0 and 2) against a timestamp-based behavioural model.
module tb_pwm_deadtime_gen;
  logic CLK = 0, RST = 1, EN = 0, DUTY_VLD = 0;
  logic [3:0] CNT = 0;
  logic [4:0] DUTY_IN = 0;
  logic rdy0, h0, l0, stb0, rdy2, h2, l2, stb2;
  int n_chk = 0, n_fail = 0, t = 0;
  int m_act, m_pend;
  bit m_full, m_rdy, m_stb;
  int mode[2], lvl[2], dk[2], acc[4];
  int dts[2] = '{0, 2};

  pwm_deadtime_gen #(.CW(4), .DT(0)) u0 (.CLK(CLK), .RST(RST), .CNT(CNT), .EN(EN), .DUTY_IN(DUTY_IN),
    .DUTY_VLD(DUTY_VLD), .DUTY_RDY(rdy0), .PWM_H(h0), .PWM_L(l0), .PRD_STB(stb0));
  pwm_deadtime_gen #(.CW(4), .DT(2)) u2 (.CLK(CLK), .RST(RST), .CNT(CNT), .EN(EN), .DUTY_IN(DUTY_IN),
    .DUTY_VLD(DUTY_VLD), .DUTY_RDY(rdy2), .PWM_H(h2), .PWM_L(l2), .PRD_STB(stb2));

  always #5 CLK = ~CLK;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_pend = 0; m_full = 0; m_rdy = 0; m_stb = 0;
    mode = '{0, 0};
  endtask

  // mode: 0 off, 1 dark until dk, 2 driving lvl
  task automatic model_edge();
    bit bnd, xfer, raw;
    int de;
    bnd = CNT == 0;
    xfer = DUTY_VLD && m_rdy;
    de = (bnd && m_full) ? m_pend : m_act;
    raw = int'(CNT) < de;
    m_rdy = !m_full && !xfer;
    if (bnd && m_full) begin m_act = m_pend; m_full = 0; end
    if (xfer) begin m_pend = DUTY_IN > 16 ? 16 : int'(DUTY_IN); m_full = 1; end
    m_stb = bnd;
    for (int k = 0; k < 2; k++) begin
      if (!EN) mode[k] = 0;
      else if (mode[k] == 1) begin
        if (t >= dk[k]) begin mode[k] = 2; lvl[k] = int'(raw); end
      end else if (mode[k] == 0 || lvl[k] != int'(raw)) begin
        if (dts[k] == 0) begin mode[k] = 2; lvl[k] = int'(raw); end
        else begin mode[k] = 1; dk[k] = t + dts[k]; end
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    if (RST) model_reset(); else model_edge();
    #1;
    chk("h0", int'(h0), int'(mode[0] == 2 && lvl[0] == 1));
    chk("l0", int'(l0), int'(mode[0] == 2 && lvl[0] == 0));
    chk("h2", int'(h2), int'(mode[1] == 2 && lvl[1] == 1));
    chk("l2", int'(l2), int'(mode[1] == 2 && lvl[1] == 0));
    chk("stb0", int'(stb0), int'(m_stb));
    chk("stb2", int'(stb2), int'(m_stb));
    chk("rdy0", int'(rdy0), int'(m_rdy));
    chk("rdy2", int'(rdy2), int'(m_rdy));
    chk("excl2", int'(h2 & l2), 0);
    acc[0] += int'(h0); acc[1] += int'(l0); acc[2] += int'(h2); acc[3] += int'(l2);
    t++;
    CNT = CNT + 4'd1;
  endtask

  task automatic run_period();
    while (CNT != 0) step();
    acc = '{0, 0, 0, 0};
    repeat (16) step();
  endtask

  task automatic chk_acc(string tag, int e0h, int e0l, int e2h, int e2l);
    chk({tag, "_h0w"}, acc[0], e0h);
    chk({tag, "_l0w"}, acc[1], e0l);
    chk({tag, "_h2w"}, acc[2], e2h);
    chk({tag, "_l2w"}, acc[3], e2l);
  endtask

  task automatic write_duty(int d);
    int n = 0;
    while (!rdy0 && n < 40) begin step(); n++; end
    chk("rdy_wait", int'(rdy0), 1);
    DUTY_VLD = 1;
    DUTY_IN = 5'(d);
    step();
    DUTY_VLD = 0;
  endtask

  task automatic duty_test(string tag, int d, int e0h, int e0l, int e2h, int e2l);
    write_duty(d);
    run_period();
    run_period();
    chk_acc(tag, e0h, e0l, e2h, e2l);
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    RST = 0;
    step();
    chk("rst_rdy", int'(rdy0), 1);
    EN = 1;
    duty_test("d8", 8, 8, 8, 6, 6);
    while (CNT != 3) step();
    chk("pre_rst_h0", int'(h0), 1);
    #3 RST = 1;
    #1;
    chk("arst_h0", int'(h0), 0);
    chk("arst_l2", int'(l2), 0);
    chk("arst_stb", int'(stb0), 0);
    chk("arst_rdy", int'(rdy0), 0);
    model_reset();
    step();
    RST = 0;
    step();
    chk("rel_rdy", int'(rdy0), 1);
    while (CNT != 4) step();
    DUTY_VLD = 1; DUTY_IN = 4;
    step();
    DUTY_IN = 12;
    step();
    chk("bp_stall", int'(rdy0), 0);
    while (CNT != 0) step();
    acc = '{0, 0, 0, 0};
    step();
    chk("bp_stb", int'(stb0), 1);
    chk("bp_rdy_bnd", int'(rdy0), 0);
    step();
    chk("bp_rdy_rise", int'(rdy0), 1);
    step();
    DUTY_VLD = 0;
    chk("bp_rdy_take", int'(rdy0), 0);
    repeat (13) step();
    chk_acc("bp4", 4, 12, 2, 10);
    run_period();
    chk_acc("bp12", 12, 4, 10, 2);
    duty_test("d0", 0, 0, 16, 0, 16);
    duty_test("d16", 16, 16, 0, 16, 0);
    duty_test("d0b", 0, 0, 16, 0, 16);
    duty_test("d20", 20, 16, 0, 16, 0);
    duty_test("d8b", 8, 8, 8, 6, 6);
    while (CNT != 3) step();
    chk("pre_en_h0", int'(h0), 1);
    EN = 0;
    step();
    chk("en_off_h0", int'(h0 | l0), 0);
    chk("en_off_h2", int'(h2 | l2), 0);
    step();
    EN = 1;
    step();
    chk("en_res0", int'(h0 | l0), 1);
    chk("en_dark_a", int'(h2 | l2), 0);
    step();
    chk("en_dark_b", int'(h2 | l2), 0);
    step();
    chk("en_res2", int'(h2 | l2), 1);
    repeat (1500) begin
      EN = $urandom_range(0, 19) != 0;
      DUTY_VLD = $urandom_range(0, 1) == 1;
      DUTY_IN = 5'($urandom_range(0, 31));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
